// File: rtl/window_addr_gen.sv
// window_addr_gen: streams LANES word addresses per beat for a
// WIN_ROWS x WIN_COLS window under valid/ready. It also reports the base
// address of the next window, slid one word to the right.
module window_addr_gen #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4,
    parameter int WIN_COLS   = 4,
    parameter int WIN_ROWS   = 4,
    parameter int LANES      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDR_W-1:0]       base_i,
    input  logic [ADDR_W-1:0]       row_stride_i,
    input  logic                    ready_i,
    output logic [LANES*ADDR_W-1:0] addr_o,
    output logic                    valid_o,
    output logic                    last_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [ADDR_W-1:0]       next_base_o
);

    localparam int NUM_GRP = WIN_COLS / LANES;
    localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int ROW_W   = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
    localparam logic [ADDR_W-1:0] GRP_BYTES = ADDR_W'(LANES * WORD_BYTES);
    localparam logic [GRP_W-1:0]  GRP_MAX   = GRP_W'(NUM_GRP - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(WIN_ROWS - 1);
    // A 1x1-beat window is already on its last beat when it starts.
    localparam logic ONE_BEAT = (NUM_GRP == 1) && (WIN_ROWS == 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q;
    logic [ADDR_W-1:0]       row_base_q, row_base_d;
    logic [ADDR_W-1:0]       stride_q;
    logic [ADDR_W-1:0]       col_off_q, col_off_d;
    logic [GRP_W-1:0]        grp_q, grp_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic                    last_d;
    logic [LANES*ADDR_W-1:0] addr_q;
    logic                    valid_q, last_q, busy_q, done_q;
    logic [ADDR_W-1:0]       next_base_q;

    // Lane offsets are constants; only the beat base needs an adder chain.
    function automatic logic [LANES*ADDR_W-1:0] lanes_of(input logic [ADDR_W-1:0] b);
        logic [LANES*ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[i*ADDR_W +: ADDR_W] = b + ADDR_W'(i * WORD_BYTES);
        return r;
    endfunction

    // Position of the beat that follows the current one (column group or row wrap).
    always_comb begin
        grp_d      = grp_q + GRP_W'(1);
        row_d      = row_q;
        row_base_d = row_base_q;
        col_off_d  = col_off_q + GRP_BYTES;
        if (grp_q == GRP_MAX) begin
            grp_d      = '0;
            row_d      = row_q + ROW_W'(1);
            row_base_d = row_base_q + stride_q;
            col_off_d  = '0;
        end
        last_d = (row_d == ROW_MAX) && (grp_d == GRP_MAX);
    end

    // Control FSM with registered outputs; counters advance only on a handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            row_base_q  <= '0;
            stride_q    <= '0;
            col_off_q   <= '0;
            grp_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            next_base_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        row_base_q  <= base_i;
                        stride_q    <= row_stride_i;
                        col_off_q   <= '0;
                        grp_q       <= '0;
                        row_q       <= '0;
                        addr_q      <= lanes_of(base_i);
                        valid_q     <= 1'b1;
                        last_q      <= ONE_BEAT;
                        busy_q      <= 1'b1;
                        next_base_q <= base_i + ADDR_W'(WORD_BYTES);
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (valid_q && ready_i) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            grp_q      <= grp_d;
                            row_q      <= row_d;
                            row_base_q <= row_base_d;
                            col_off_q  <= col_off_d;
                            addr_q     <= lanes_of(row_base_d + col_off_d);
                            last_q     <= last_d;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign addr_o      = addr_q;
    assign valid_o     = valid_q;
    assign last_o      = last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign next_base_o = next_base_q;

endmodule

// File: doc/window_addr_gen.md
# window_addr_gen

Sequential, parametrised address generator for the SAD datapath's window fetch. Given a window base byte address and a frame row stride, it streams word addresses for a WIN_ROWS × WIN_COLS window, LANES addresses per beat, under a valid/ready handshake. It replaces the single-row, fixed-16-offset adder bank: it handles multi-row windows, arbitrary window sizes and memory-side backpressure, and it reports the next window base for column sliding.

## Interface
- ADDR_W, 32, address width in bits; all address arithmetic is modulo 2^ADDR_W.
- WORD_BYTES, 4, byte increment between adjacent words in a row.
- WIN_COLS, 4, window width in words; must be a nonzero multiple of LANES.
- WIN_ROWS, 4, window height in rows; must be ≥ 1.
- LANES, 4, number of addresses emitted per beat.

- Clk  in  1  single clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  launch request; sampled only in IDLE.
- Base  in  ADDR_W  window top-left byte address; latched on accepted Start.
- RowStride  in  ADDR_W  byte distance between frame rows; latched on accepted Start.
- Ready  in  1  consumer accepts the current beat.
- Addr  out  LANES*ADDR_W  lane i at bits [i*ADDR_W +: ADDR_W].
- Valid  out  1  Addr holds a beat.
- Last  out  1  current beat is the final beat of the window; qualified by Valid.
- Busy  out  1  high in RUN and DONE.
- Done  out  1  one-cycle pulse after the final handshake.
- NextBase  out  ADDR_W  latched Base + WORD_BYTES, i.e. the next column-slid window.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: when Start=1, latch Base into row_base and RowStride, clear col_grp and row counters, load NextBase, and go to RUN. Otherwise remain in IDLE.
- RUN: Valid=1. Lane i address = row_base + (col_grp*LANES + i)*WORD_BYTES. Lane offsets are constants; col_grp*LANES*WORD_BYTES comes from an accumulator. No multiplier.
- Handshake: a beat completes when Valid && Ready.
  - If Ready=0, Addr, Last and all counters hold.
  - On handshake with col_grp < WIN_COLS/LANES−1: increment col_grp.
  - On handshake at the end of a row: clear col_grp, add RowStride to row_base, and increment row.
  - On handshake with Last=1: go to DONE.
- Last=1 when row = WIN_ROWS−1 and col_grp = WIN_COLS/LANES−1.
- Total beats per window = WIN_ROWS·WIN_COLS/LANES.
- DONE: Valid=0, Done=1 for exactly one cycle, then go to IDLE.
- Start is ignored in RUN and DONE. It is not queued.
- Base, RowStride and Ready changes outside the relevant sample points have no effect.
- NextBase stays stable from the accepted Start until the next accepted Start.
- Wrap-around: all additions truncate to ADDR_W bits. No overflow flag.
- Reset values: state=IDLE, Valid=0, Last=0, Busy=0, Done=0, Addr=0, NextBase=0, all counters 0.
- Rst mid-window aborts the window immediately with no Done pulse. Rst takes priority over Start in the same cycle.

## Timing
- Start sampled high in IDLE at edge n: Valid=1 with beat 0 from cycle n+1.
- With Ready held at 1, beats complete on consecutive cycles. The final beat handshakes at edge n+B, where B is the total beat count.
- Done is high during the cycle after the final handshake. IDLE is entered the cycle after that.
- Earliest next accepted Start is one cycle after Done; minimum issue interval = B+2 cycles.
- Outputs are registered. Ready to counter advance is one edge; there is no combinational Ready to Valid path.

## Test plan
- Defaults, Base=0x1000, RowStride=0x40, Ready=1:
  - Beat 0 = 0x1000/0x1004/0x1008/0x100C.
  - Beat 1 = 0x1040..0x104C.
  - Beat 3 = 0x10C0..0x10CC with Last=1.
  - Done one cycle later; NextBase=0x1004; 4 beats total.
- Backpressure: same setup with Ready toggling 1,0,0,1,…:
  - Addr is stable while Ready=0.
  - No beat is skipped or duplicated.
  - Done follows the fourth handshake.
- Wrap: Base=0xFFFFFFF8, RowStride=0x10:
  - Beat 0 = 0xFFFFFFF8/0xFFFFFFFC/0x00000000/0x00000004.
  - Beat 1 starts at 0x00000008.
  - NextBase=0xFFFFFFFC.
- Reset and Start ignore:
  - Start is pulsed again during RUN: it is ignored.
  - Rst is asserted at beat 2: all outputs return to reset values next cycle, with no Done pulse.
  - A fresh Start then yields beat 0 from the new Base.
- Parametrised geometry: LANES=2, WIN_COLS=8, WIN_ROWS=3, Base=0x2000, RowStride=0x100:
  - 12 beats.
  - Beat 3 = 0x2018/0x201C.
  - Beat 4 = 0x2100/0x2104.
  - Last on beat 11 = 0x2218/0x221C.
